// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states,
// lane masks and small access-size helpers.
package lsu_pkg;

    // RV32I load/store funct3 encodings (stores reuse B/H/W)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Controller states, 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LD_RESP   = 2'd1,
        ST_RMW_MERGE = 2'd2,
        ST_DONE      = 2'd3
    } lsu_state_e;

    // Lane masks, positioned at lane 0 and shifted by the byte offset
    localparam logic [31:0] LANE_BYTE_MASK = 32'h0000_00FF;
    localparam logic [31:0] LANE_HALF_MASK = 32'h0000_FFFF;

    // Size field 1x (010, 011, 110, 111) is treated as a full word
    function automatic logic is_word_access(input logic [2:0] f3);
        return f3[1];
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        if (f3[1]) begin
            mis = (off != 2'b00);
        end else if (f3[0]) begin
            mis = off[0];
        end
        return mis;
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: load extraction with sign/zero extension and
// store merge of a byte or halfword into an existing word.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [31:0] ld_word,
    input  logic [1:0]  ld_offset,
    input  logic [2:0]  ld_funct3,
    output logic [31:0] ld_data,
    input  logic [31:0] st_old,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_offset,
    input  logic [1:0]  st_size,
    output logic [31:0] st_word
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [4:0]  st_shift;
    logic [31:0] st_mask;

    // Select the addressed byte/halfword and extend it per funct3
    always_comb begin
        ld_data = ld_word;
        case (ld_offset)
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        ld_half = ld_offset[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_funct3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data = {24'h00_0000, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data = {16'h0000, ld_half};
            F3_W:    ld_data = ld_word;
            default: ld_data = ld_word;
        endcase
    end

    // Replace only the targeted lane of the old word; words pass straight through
    always_comb begin
        st_shift = {st_offset, 3'b000};
        st_mask  = '0;
        st_word  = st_data;
        if (!st_size[1]) begin
            st_mask = (st_size[0] ? LANE_HALF_MASK : LANE_BYTE_MASK) << st_shift;
            st_word = (st_old & ~st_mask) | ((st_data << st_shift) & st_mask);
        end
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between EX/MEM and a word-wide data memory without byte
// enables. Sub-word stores use read-modify-write; errors skip the memory.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned MEMORY_SIZE = 2048,
    parameter int unsigned ADDR_WIDTH  = $clog2(MEMORY_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_misaligned,
    output logic                  resp_range_err,
    output logic [ADDR_WIDTH-1:0] dm_addr,
    output logic                  dm_we,
    output logic                  dm_re,
    output logic [31:0]           dm_wdata,
    input  logic [31:0]           dm_rdata
);

    lsu_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            off_q;
    logic [2:0]            funct3_q;
    logic [31:0]           wdata_q;

    logic                  accept;
    logic                  req_mis, req_rng, req_err, req_sw;
    logic [31:0]           req_hi;
    logic [ADDR_WIDTH-1:0] req_word;
    logic [31:0]           ld_data, st_word;

    assign req_ready  = (state_q == ST_IDLE);
    assign accept     = req_ready && req_valid;
    assign req_hi     = req_addr >> (ADDR_WIDTH + 2);
    assign req_word   = req_addr[ADDR_WIDTH+1:2];
    assign req_mis    = is_misaligned(req_funct3, req_addr[1:0]);
    assign req_rng    = |req_hi;
    assign req_err    = req_mis || req_rng;
    assign req_sw     = req_we && is_word_access(req_funct3);
    assign resp_valid = (state_q == ST_DONE);

    lsu_byte_lane u_lane (
        .ld_word   (dm_rdata),
        .ld_offset (off_q),
        .ld_funct3 (funct3_q),
        .ld_data   (ld_data),
        .st_old    (dm_rdata),
        .st_data   (wdata_q),
        .st_offset (off_q),
        .st_size   (funct3_q[1:0]),
        .st_word   (st_word)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and memory strobes; dm_we decodes state so reset kills it at once
    always_comb begin
        state_d  = state_q;
        dm_we    = 1'b0;
        dm_re    = 1'b0;
        dm_wdata = '0;
        // Registered address, bypassed from the request in the accept cycle so
        // the memory samples the new address on the accepting edge.
        dm_addr  = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    dm_addr = req_word;
                    if (req_err) begin
                        state_d = ST_DONE;
                    end else if (!req_we) begin
                        dm_re   = 1'b1;
                        state_d = ST_LD_RESP;
                    end else if (req_sw) begin
                        dm_we    = 1'b1;
                        dm_wdata = req_wdata;
                        state_d  = ST_DONE;
                    end else begin
                        dm_re   = 1'b1;
                        state_d = ST_RMW_MERGE;
                    end
                end
            end
            ST_LD_RESP: begin
                state_d = ST_DONE;
            end
            ST_RMW_MERGE: begin
                dm_we    = 1'b1;
                dm_wdata = st_word;
                state_d  = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Capture the request on acceptance; held until the next acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            off_q    <= '0;
            funct3_q <= '0;
            wdata_q  <= '0;
        end else if (accept) begin
            addr_q   <= req_word;
            off_q    <= req_addr[1:0];
            funct3_q <= req_funct3;
            wdata_q  <= req_wdata;
        end
    end

    // Response registers, updated only on the transition into DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_rdata      <= '0;
            resp_misaligned <= 1'b0;
            resp_range_err  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept && (req_err || req_sw)) begin
                        resp_rdata      <= '0;
                        resp_misaligned <= req_mis;
                        resp_range_err  <= req_rng;
                    end
                end
                ST_LD_RESP: begin
                    resp_rdata      <= ld_data;
                    resp_misaligned <= 1'b0;
                    resp_range_err  <= 1'b0;
                end
                ST_RMW_MERGE: begin
                    resp_rdata      <= '0;
                    resp_misaligned <= 1'b0;
                    resp_range_err  <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit between the EX/MEM pipeline stage and `data_mem`, the word-wide data memory.
- `data_mem` has a synchronous read with one-cycle latency, a synchronous write, and no byte enables.
- This block converts RV32I byte addresses to word addresses and performs LB/LH/LW/LBU/LHU extraction with sign or zero extension.
- SB/SH are implemented as a read-modify-write sequence; misaligned and out-of-range accesses are flagged.

Parameters:
- MEMORY_SIZE, 2048: data memory depth in 32-bit words; must match `data_mem`.
- ADDR_WIDTH, $clog2(MEMORY_SIZE): word-address width driven to `data_mem`.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present; sampled only while req_ready=1.
- req_ready  out  1  LSU idle and able to accept a request.
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RV32I funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101, SB 000, SH 001, SW 010.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low byte or halfword is used for SB/SH.
- resp_valid  out  1  one-cycle pulse: access complete.
- resp_rdata  out  32  extended load result; valid while resp_valid=1.
- resp_misaligned  out  1  qualifies resp_valid: misaligned access.
- resp_range_err  out  1  qualifies resp_valid: address beyond MEMORY_SIZE words.
- dm_addr  out  ADDR_WIDTH  word address to `data_mem`, equal to addr[ADDR_WIDTH+1:2].
- dm_we  out  1  write enable to `data_mem`.
- dm_re  out  1  read enable to `data_mem`.
- dm_wdata  out  32  write data to `data_mem`.
- dm_rdata  in  32  registered read data from `data_mem`.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - resp_valid, resp_rdata, resp_misaligned, resp_range_err all 0.
  - dm_we, dm_re = 0.
  - dm_addr and captured request registers = 0.
- States: IDLE, LD_RESP, RMW_MERGE, DONE.
- dm_addr comes from a registered word address. It is loaded on acceptance and held until the state returns to IDLE, because `data_mem` reads mem[addr] every non-write cycle.
- req_ready=1 only in IDLE. Requests while req_ready=0 are ignored; the requester holds its request.
- Error checks at acceptance (IDLE & req_valid):
  - Misaligned: halfword access with addr[0]=1, or word access with addr[1:0]≠0.
  - Range error: addr[31:ADDR_WIDTH+2]≠0.
  - Either condition → no memory write; capture the flags; go to DONE.
- Load accepted, cycle T:
  - dm_re=1, dm_we=0; capture funct3 and addr[1:0]; go to LD_RESP.
- LD_RESP, cycle T+1 (dm_rdata valid):
  - Select the byte or halfword by the captured offset.
  - Sign-extend for LB/LH, zero-extend for LBU/LHU; LW passes the word through.
  - Register the result into resp_rdata; go to DONE.
- SW accepted:
  - dm_we=1 combinationally in the accept cycle, dm_wdata=req_wdata, addr taken from req_addr; go to DONE.
  - Total latency: resp at T+1.
- SB/SH accepted, cycle T:
  - dm_re=1; go to RMW_MERGE.
- RMW_MERGE, cycle T+1:
  - Merge the store byte or halfword into dm_rdata at the captured lane.
  - dm_we=1, dm_wdata=merged word; go to DONE.
- DONE:
  - resp_valid=1 for exactly one cycle with the flags; return to IDLE.
  - Flags and resp_rdata hold their value until the next response.
  - resp_rdata=0 for stores and errors.
- dm_we is a combinational decode of state (plus the SW accept term), so reset mid-sequence deasserts it immediately and no partial write occurs.
- funct3 values 011, 110 and 111 are treated as LW/SW-width accesses for alignment and must not be issued; they are not flagged.
- Back-to-back requests: a new request can be accepted in the IDLE cycle right after DONE.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State encoding localparams (2-bit).
  - Lane-select helper constants.
- Sub-module lsu_byte_lane: purely combinational. It performs load extraction/extension (word, offset, funct3 → 32b) and store merge (old word, new data, offset, size → 32b). This keeps the FSM file small and lets the lane logic be tested in isolation.

Test Plan:
- Preload word index 4 = 0x876543A1.
  - LB 0x10 → resp_rdata=0xFFFFFFA1 with resp_valid at T+2.
  - LBU 0x11 → 0x00000043.
  - LH 0x12 → 0xFFFF8765.
  - LHU 0x12 → 0x00008765.
- SB 0x13, wdata=0x000000CC → dm_we high only at T+1; word 4 becomes 0xCC6543A1. Then SH 0x10, wdata=0x1234 → 0xCC651234. Read back with LW 0x10.
- SW 0x20, wdata=0xDEADBEEF → dm_we at T, resp_valid at T+1. LW 0x20 returns 0xDEADBEEF.
- SH 0x13 and LW 0x22 → resp_misaligned=1, no dm_we pulse, word 4 and word 8 unchanged.
- SW 0x2000 (word 2048, default size) → resp_range_err=1, no dm_we.
- Assert rst_n=0 during RMW_MERGE of SB 0x14 → dm_we drops the same cycle, memory unchanged, all outputs 0. After release, req_ready=1 and a new LW completes normally.
